word_packer: RTL and testbench
==============================

Name: word_packer

Overview:
- Upstream feeder for the vocabulary matcher.
- Accepts a byte stream (one character per beat) and splits it on a delimiter byte.
- Packs each token into a fixed-width word of WORD_LENGTH bytes, MSB-first and zero-padded, and hands it to the matcher's word input over a valid/ready handshake.
- Tokens longer than WORD_LENGTH are truncated and flagged so the matcher side can treat them as inexact.

Parameters:
- WORD_LENGTH, 3: bytes per packed word.
- DATA_WIDTH, 8: bits per character.
- DELIM, 8'h20: delimiter byte that ends a token; never stored.
- PAD, 8'h00: fill value for unused byte slots.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- byte_in  in  DATA_WIDTH  input character.
- byte_valid  in  1  byte_in valid.
- byte_last  in  1  end of stream; qualifies the current byte.
- byte_ready  out  1  packer can accept a byte.
- word  out  WORD_LENGTH*DATA_WIDTH  packed token; first char in bits [WORD_LENGTH*DATA_WIDTH-1 -: DATA_WIDTH].
- word_len  out  $clog2(WORD_LENGTH+1)  number of stored characters, 1..WORD_LENGTH.
- word_trunc  out  1  token exceeded WORD_LENGTH; extra chars dropped.
- word_valid  out  1  word/word_len/word_trunc valid.
- word_ready  in  1  matcher accepts word.

Behaviour:
- Clock/reset: single clock clk; synchronous active-high rst. Reset wins over any same-cycle event and may occur mid-token; the partial token is discarded.
- Reset values: word = all PAD, word_len = 0, word_trunc = 0, word_valid = 0, state FILL, byte_ready = 1 in the first cycle after reset.
- Byte accept: byte_valid && byte_ready. Word accept: word_valid && word_ready.
- FSM states: FILL, SKIP, OUT. byte_ready = (state != OUT).
- FILL, non-DELIM byte accepted, count < WORD_LENGTH:
  - Store the byte at slot count (slot 0 = MSB); count++.
  - If byte_last and the byte was stored: go OUT.
- FILL, non-DELIM byte accepted, count == WORD_LENGTH:
  - Byte dropped; set trunc.
  - byte_last: go OUT. Otherwise go SKIP.
- FILL, DELIM accepted: count > 0 -> OUT. count == 0 -> stay FILL, no word emitted (consecutive delimiters and leading delimiters are dropped).
- FILL, byte_last on DELIM or on empty buffer: no word emitted.
- SKIP: non-DELIM bytes dropped. DELIM or byte_last -> OUT with trunc = 1.
- OUT:
  - word_valid = 1; word/word_len/word_trunc held stable until word accept.
  - On word accept: clear buffer to PAD, count = 0, trunc = 0, next state FILL.
- Latency: word_valid rises the cycle after the terminating byte is accepted.
- Throughput: one byte per cycle; at least one bubble per emitted word (byte_ready = 0 in OUT).
- Output encoding: word_len = count in the emitted word; unused slots = PAD.
- Widths: count is $clog2(WORD_LENGTH+1) bits and saturates at WORD_LENGTH.
- byte_last ignored when byte_valid = 0.

Optional Feature:
- Macro: WORD_PACKER_STATS_EN.
- When defined:
  - Adds outputs stat_words (16b) and stat_trunc (16b).
  - stat_words increments on every word accept.
  - stat_trunc increments on every word accept with word_trunc = 1.
  - Both wrap at 16'hFFFF -> 0 and clear on rst.
- When undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Bytes "Hel", DELIM, word_ready = 1 -> word = 24'h48656C, word_len = 3, word_trunc = 0, one cycle after DELIM accepted.
- Bytes "Hi", DELIM -> word = 24'h486900, word_len = 2, word_trunc = 0.
- Bytes "Hello", DELIM -> single word 24'h48656C, word_len = 3, word_trunc = 1; next byte 'A' starts a fresh token.
- Backpressure: word_ready low 5 cycles after word_valid -> word stable, byte_ready = 0 throughout, then word accepted and byte_ready = 1 the next cycle.
- Edge cases:
  - DELIM, DELIM, 'A' with byte_last -> exactly one word 24'h410000, word_len = 1.
  - Lone DELIM with byte_last -> no word.
- rst asserted after "He" -> outputs at reset values. Subsequent "Ok", DELIM -> word = 24'h4F6B00, word_len = 2.
- With WORD_PACKER_STATS_EN: the above sequence yields stat_words and stat_trunc matching the emitted word count and truncated word count.

Source files
------------

// File: rtl/word_packer_if.sv
// Byte-stream in / packed-word out bundle between the tokenizer source and the vocabulary matcher.
// master drives bytes and word_ready; slave is the packer.
`timescale 1ns/1ps
interface word_packer_if #(
    parameter int WORD_LENGTH = 3,
    parameter int DATA_WIDTH  = 8
) ();
    logic [DATA_WIDTH-1:0]             byte_in;
    logic                              byte_valid;
    logic                              byte_last;
    logic                              byte_ready;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
    logic [$clog2(WORD_LENGTH+1)-1:0]  word_len;
    logic                              word_trunc;
    logic                              word_valid;
    logic                              word_ready;

    modport master (
        output byte_in, byte_valid, byte_last, word_ready,
        input  byte_ready, word, word_len, word_trunc, word_valid
    );

    modport slave (
        input  byte_in, byte_valid, byte_last, word_ready,
        output byte_ready, word, word_len, word_trunc, word_valid
    );
endinterface

// File: rtl/word_packer.sv
// Splits a byte stream on DELIM and packs each token MSB-first into a WORD_LENGTH-byte word.
// Optional accept counters are compiled in with WORD_PACKER_STATS_EN.
`timescale 1ns/1ps
module word_packer #(
    parameter int                    WORD_LENGTH = 3,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] DELIM       = 8'h20,
    parameter logic [DATA_WIDTH-1:0] PAD         = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    word_packer_if.slave bus
`ifdef WORD_PACKER_STATS_EN
    ,
    output logic [15:0]  stat_words,
    output logic [15:0]  stat_trunc
`endif
);
    localparam int CW = $clog2(WORD_LENGTH + 1);

    typedef enum logic [1:0] {FILL, SKIP, OUT} state_t;

    state_t                            state_reg, state_next;
    logic [CW-1:0]                     count_reg, count_next;
    logic                              trunc_reg, trunc_next;
    logic                              store_en;
    logic                              clear_en;
    logic                              byte_acc;
    logic                              word_acc;
    logic                              is_delim;
    logic [WORD_LENGTH*DATA_WIDTH-1:0] word_flat;

    assign byte_acc = bus.byte_valid && (state_reg != OUT);
    assign word_acc = (state_reg == OUT) && bus.word_ready;
    assign is_delim = (bus.byte_in == DELIM);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        trunc_next = trunc_reg;
        store_en   = 1'b0;
        clear_en   = 1'b0;
        case (state_reg)
            FILL: begin
                if (byte_acc) begin
                    if (is_delim) begin
                        // Leading and repeated delimiters produce no empty words.
                        if (count_reg != '0)
                            state_next = OUT;
                    end else if (count_reg < CW'(WORD_LENGTH)) begin
                        store_en   = 1'b1;
                        count_next = count_reg + CW'(1);
                        if (bus.byte_last)
                            state_next = OUT;
                    end else begin
                        trunc_next = 1'b1;
                        state_next = bus.byte_last ? OUT : SKIP;
                    end
                end
            end
            SKIP: begin
                if (byte_acc && (is_delim || bus.byte_last))
                    state_next = OUT;
            end
            OUT: begin
                if (word_acc) begin
                    clear_en   = 1'b1;
                    count_next = '0;
                    trunc_next = 1'b0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
            count_reg <= '0;
            trunc_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            trunc_reg <= trunc_next;
        end
    end

    // One register per byte slot; slot 0 lands in the most significant byte.
    for (genvar gi = 0; gi < WORD_LENGTH; gi++) begin : g_slot
        logic [DATA_WIDTH-1:0] slot_reg;

        always_ff @(posedge clk) begin
            if (rst || clear_en)
                slot_reg <= PAD;
            else if (store_en && (count_reg == CW'(gi)))
                slot_reg <= bus.byte_in;
        end

        assign word_flat[(WORD_LENGTH-1-gi)*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
    end

    assign bus.byte_ready = (state_reg != OUT);
    assign bus.word_valid = (state_reg == OUT);
    assign bus.word       = word_flat;
    assign bus.word_len   = count_reg;
    assign bus.word_trunc = trunc_reg;

`ifdef WORD_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_words <= '0;
            stat_trunc <= '0;
        end else if (word_acc) begin
            stat_words <= stat_words + 16'd1;
            if (trunc_reg)
                stat_trunc <= stat_trunc + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: directed test-plan cases plus randomized streams
// checked against a token-level reference model.
`timescale 1ns/1ps
module tb_word_packer;
    localparam int WL = 3;
    localparam int DW = 8;
    localparam int LW = $clog2(WL + 1);
    localparam logic [7:0] DELIM = 8'h20;

    typedef struct packed {
        logic [WL*DW-1:0] w;
        logic [LW-1:0]    len;
        logic             trunc;
    } wrec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    word_packer_if #(.WORD_LENGTH(WL), .DATA_WIDTH(DW)) bus ();

`ifdef WORD_PACKER_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_trunc;
`endif

    word_packer #(
        .WORD_LENGTH(WL),
        .DATA_WIDTH (DW),
        .DELIM      (8'h20),
        .PAD        (8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WORD_PACKER_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_trunc(stat_trunc)
`endif
    );

    wrec_t got_q[$];
    wrec_t exp_q[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    ready_mode = 0;   // 0: always ready, 1: random, 2: manual_ready
    logic  manual_ready = 1'b0;
    int    exp_words = 0;
    int    exp_trunc = 0;

    // word_ready is updated first so the sample matches what the next posedge sees.
    always @(negedge clk) begin
        if (ready_mode == 0)
            bus.word_ready = 1'b1;
        else if (ready_mode == 1)
            bus.word_ready = ($urandom_range(0, 2) != 0);
        else
            bus.word_ready = manual_ready;
        if (!rst && bus.word_valid && bus.word_ready) begin
            got_q.push_back('{w: bus.word, len: bus.word_len, trunc: bus.word_trunc});
            $display("word accepted: %h len %0d trunc %0d", bus.word, bus.word_len, bus.word_trunc);
        end
    end

    function automatic wrec_t pack_tok(input logic [7:0] tok[$], input bit over);
        wrec_t r;
        r.w = '0;
        for (int i = 0; i < tok.size(); i++)
            r.w[(WL-1-i)*DW +: DW] = tok[i];
        r.len   = LW'(tok.size());
        r.trunc = over;
        return r;
    endfunction

    // Token-level model: split on DELIM, keep the first WL chars, flag anything longer.
    task automatic model_stream(input logic [7:0] bs[$], input bit ls[$]);
        logic [7:0] tok[$];
        bit over = 0;
        for (int i = 0; i < bs.size(); i++) begin
            if (bs[i] == DELIM) begin
                if (tok.size() > 0) begin
                    exp_q.push_back(pack_tok(tok, over));
                    exp_words++; if (over) exp_trunc++;
                    tok.delete(); over = 0;
                end
            end else if (tok.size() < WL) begin
                tok.push_back(bs[i]);
            end else begin
                over = 1;
            end
            if (ls[i] && tok.size() > 0) begin
                exp_q.push_back(pack_tok(tok, over));
                exp_words++; if (over) exp_trunc++;
                tok.delete(); over = 0;
            end
        end
    endtask

    // Entered and left on a negedge; returns on the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input bit last, input bit gaps);
        int guard = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.byte_valid = 1'b0;
            bus.byte_last  = 1'b1;
            bus.byte_in    = DELIM;
            @(negedge clk);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        bus.byte_last  = last;
        while (!bus.byte_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            compared++; mismatched++;
            $display("FAIL byte_accept_timeout: byte_ready stayed %b, required 1", bus.byte_ready);
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
    endtask

    task automatic drive_stream(input logic [7:0] bs[$], input bit ls[$], input bit gaps);
        model_stream(bs, ls);
        for (int i = 0; i < bs.size(); i++)
            send_byte(bs[i], ls[i], gaps);
    endtask

    task automatic clear_queues();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_queues(input string name);
        int guard = 0;
        while (got_q.size() < exp_q.size() && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        compared++;
        if (got_q.size() != exp_q.size()) begin
            mismatched++;
            $display("FAIL %s_count: got %0d words, required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            compared++;
            if (got_q[i] !== exp_q[i]) begin
                mismatched++;
                $display("FAIL %s_word%0d: got %h/%0d/%0d, required %h/%0d/%0d", name, i,
                         got_q[i].w, got_q[i].len, got_q[i].trunc,
                         exp_q[i].w, exp_q[i].len, exp_q[i].trunc);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name);
        compared++;
        if (bus.word !== 24'h000000) begin
            mismatched++; $display("FAIL %s_word: got %h, required 000000", name, bus.word);
        end
        compared++;
        if (bus.word_len !== 2'd0) begin
            mismatched++; $display("FAIL %s_len: got %0d, required 0", name, bus.word_len);
        end
        compared++;
        if (bus.word_trunc !== 1'b0) begin
            mismatched++; $display("FAIL %s_trunc: got %b, required 0", name, bus.word_trunc);
        end
        compared++;
        if (bus.word_valid !== 1'b0) begin
            mismatched++; $display("FAIL %s_valid: got %b, required 0", name, bus.word_valid);
        end
        compared++;
        if (bus.byte_ready !== 1'b1) begin
            mismatched++; $display("FAIL %s_byte_ready: got %b, required 1", name, bus.byte_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_words = 0; exp_trunc = 0;
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    // Checks the word present on the bus right after the terminating byte was accepted.
    task automatic check_live_word(input string name, input logic [23:0] w, input logic [1:0] len, input logic tr);
        compared++;
        if (bus.word_valid !== 1'b1 || bus.word !== w || bus.word_len !== len || bus.word_trunc !== tr) begin
            mismatched++;
            $display("FAIL %s_live: got valid %b %h/%0d/%0d, required valid 1 %h/%0d/%0d", name,
                     bus.word_valid, bus.word, bus.word_len, bus.word_trunc, w, len, tr);
        end
    endtask

    task automatic test_full_word();
        clear_queues();
        drive_stream('{8'h48, 8'h65, 8'h6C, DELIM}, '{0, 0, 0, 0}, 0);
        check_live_word("hel", 24'h48656C, 2'd3, 1'b0);
        check_queues("hel");
    endtask

    task automatic test_short_word();
        clear_queues();
        drive_stream('{8'h48, 8'h69, DELIM}, '{0, 0, 0}, 0);
        check_live_word("hi", 24'h486900, 2'd2, 1'b0);
        check_queues("hi");
    endtask

    task automatic test_truncation();
        clear_queues();
        drive_stream('{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, DELIM, 8'h41, DELIM},
                     '{0, 0, 0, 0, 0, 0, 0, 0}, 0);
        check_queues("hello");
        compared++;
        if (got_q.size() < 2 || got_q[0] !== wrec_t'{24'h48656C, 2'd3, 1'b1}
                             || got_q[1] !== wrec_t'{24'h410000, 2'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL hello_fixed: got %0d words (first %h), required 48656C/3/1 then 410000/1/0",
                     got_q.size(), got_q.size() > 0 ? got_q[0].w : 24'h0);
        end
    endtask

    task automatic test_delim_edges();
        clear_queues();
        drive_stream('{DELIM, DELIM, 8'h41}, '{0, 0, 1}, 0);
        check_queues("delims");
        compared++;
        if (got_q.size() != 1 || got_q[0] !== wrec_t'{24'h410000, 2'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL delims_fixed: got %0d words, required exactly 410000/1/0", got_q.size());
        end
        clear_queues();
        drive_stream('{DELIM}, '{1}, 0);
        repeat (10) @(negedge clk);
        compared++;
        if (got_q.size() != 0) begin
            mismatched++;
            $display("FAIL lone_delim: got %0d words, required 0", got_q.size());
        end
    endtask

    task automatic test_reset_mid_token();
        clear_queues();
        send_byte(8'h48, 0, 0);
        send_byte(8'h65, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_words = 0; exp_trunc = 0;
        @(negedge clk);
        check_idle_outputs("midreset");
        drive_stream('{8'h4F, 8'h6B, DELIM}, '{0, 0, 0}, 0);
        check_live_word("ok", 24'h4F6B00, 2'd2, 1'b0);
        check_queues("ok");
    endtask

    task automatic test_backpressure();
        clear_queues();
        manual_ready = 1'b0;
        ready_mode   = 2;
        @(negedge clk);
        drive_stream('{8'h41, 8'h62, 8'h63, DELIM}, '{0, 0, 0, 0}, 0);
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (bus.word_valid !== 1'b1 || bus.word !== 24'h416263 || bus.byte_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL hold_cycle%0d: got valid %b word %h byte_ready %b, required 1 416263 0",
                         i, bus.word_valid, bus.word, bus.byte_ready);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 manual_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (bus.byte_ready !== 1'b1 || bus.word_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL release: got byte_ready %b valid %b, required 1 0", bus.byte_ready, bus.word_valid);
        end
        ready_mode = 0;
        check_queues("backpressure");
    endtask

    task automatic test_random();
        logic [7:0] bs[$];
        bit         ls[$];
        int         r;
        ready_mode = 1;
        for (int round = 0; round < 3; round++) begin
            clear_queues();
            bs.delete(); ls.delete();
            for (int i = 0; i < 200; i++) begin
                r = $urandom_range(0, 9);
                bs.push_back(r < 3 ? DELIM : 8'h61 + 8'(r % 4));
                ls.push_back(i == 199 || $urandom_range(0, 40) == 0);
            end
            drive_stream(bs, ls, 1);
            check_queues($sformatf("random%0d", round));
        end
        ready_mode = 0;
    endtask

    task automatic test_stats();
`ifdef WORD_PACKER_STATS_EN
        compared++;
        if (stat_words !== 16'(exp_words)) begin
            mismatched++;
            $display("FAIL stat_words: got %0d, required %0d", stat_words, exp_words);
        end
        compared++;
        if (stat_trunc !== 16'(exp_trunc)) begin
            mismatched++;
            $display("FAIL stat_trunc: got %0d, required %0d", stat_trunc, exp_trunc);
        end
`endif
    endtask

    initial begin
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;
        bus.word_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_short_word();
        test_truncation();
        test_delim_edges();
        test_reset_mid_token();
        test_backpressure();
        test_random();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
